// File: rtl/zbuffer_pipe.sv
// zbuffer_pipe: multi-channel valid/data delay line with stall, flush,
// and an optional hold of the last delivered word on each channel.
//
// Ports:
//   clk      - single clock; all state updates on its rising edge
//   rst      - synchronous active-high reset; overrides stall and flush
//   stall    - freezes every stage and hold register
//   flush    - clears every stage and hold register; wins over stall
//   in_en    - per-channel input valid
//   in_data  - channel c in bits [c*WIDTH +: WIDTH]
//   out_en   - per-channel valid of the last stage
//   out_data - channel c in bits [c*WIDTH +: WIDTH]
//   busy     - any stage of any channel holds a valid entry
module zbuffer_pipe #(
   parameter int UUID      = 0,
   parameter     NAME      = "",
   parameter int WIDTH     = 1,
   parameter int CHANNELS  = 2,
   parameter int DEPTH     = 1,
   parameter int HOLD_LAST = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      stall,
   input  logic                      flush,
   input  logic [CHANNELS-1:0]       in_en,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   output logic [CHANNELS-1:0]       out_en,
   output logic [CHANNELS*WIDTH-1:0] out_data,
   output logic                      busy
);

   localparam int LAST = DEPTH - 1;

   if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
      $error("zbuffer_pipe: WIDTH out of range");
   end
   if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
      $error("zbuffer_pipe: CHANNELS out of range");
   end
   if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
      $error("zbuffer_pipe: DEPTH out of range");
   end
   if (UUID < 0 || $bits(NAME) > 65536) begin : g_bad_ident
      $error("zbuffer_pipe: bad identifier parameter");
   end

   logic [CHANNELS-1:0][DEPTH-1:0]            vld_q, vld_d;
   logic [CHANNELS-1:0][DEPTH-1:0][WIDTH-1:0] dat_q, dat_d;
   logic [CHANNELS-1:0][WIDTH-1:0]            hold_q, hold_d;

   always_comb begin
      vld_d  = vld_q;
      dat_d  = dat_q;
      hold_d = hold_q;
      if (flush) begin
         vld_d  = '0;
         dat_d  = '0;
         hold_d = '0;
      end else if (!stall) begin
         for (int c = 0; c < CHANNELS; c++) begin
            for (int k = LAST; k > 0; k--) begin
               vld_d[c][k] = vld_q[c][k-1];
               dat_d[c][k] = dat_q[c][k-1];
            end
            vld_d[c][0] = in_en[c];
            // Disabled inputs enter as zero so no stale data ever moves.
            dat_d[c][0] = in_en[c] ? in_data[c*WIDTH +: WIDTH] : '0;
            if (HOLD_LAST != 0 && vld_d[c][LAST]) begin
               hold_d[c] = dat_d[c][LAST];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q  <= '0;
         dat_q  <= '0;
         hold_q <= '0;
      end else begin
         vld_q  <= vld_d;
         dat_q  <= dat_d;
         hold_q <= hold_d;
      end
   end

   // Outputs decode registered state only; no path from any input.
   always_comb begin
      out_en   = '0;
      out_data = '0;
      busy     = 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
         out_en[c] = vld_q[c][LAST];
         if (vld_q[c][LAST]) begin
            out_data[c*WIDTH +: WIDTH] = dat_q[c][LAST];
         end else if (HOLD_LAST != 0) begin
            out_data[c*WIDTH +: WIDTH] = hold_q[c];
         end
         busy = busy | (|vld_q[c]);
      end
   end

endmodule

// File: tb/tb_zbuffer_pipe.sv
// tb_zbuffer_pipe: directed vectors for zbuffer_pipe, two 8x2x3 instances
// (HOLD_LAST 0 and 1) sharing stimulus, plus a 1x1x1 instance.
module tb_zbuffer_pipe;

   logic        clk = 1'b0;
   logic        rst, stall, flush;
   logic [1:0]  in_en;
   logic [15:0] in_data;
   logic [1:0]  en0, en1;
   logic [15:0] d0, d1;
   logic        b0, b1;

   logic s_rst, s_stall, s_flush, s_en, s_din;
   logic s_oen, s_dout, s_busy;

   int nvec = 0;
   int nmiss = 0;

   always #5 clk = ~clk;

   zbuffer_pipe #(.UUID(1), .NAME("z0"), .WIDTH(8), .CHANNELS(2),
      .DEPTH(3), .HOLD_LAST(0)) u_z0 (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .in_en(in_en), .in_data(in_data),
      .out_en(en0), .out_data(d0), .busy(b0));

   zbuffer_pipe #(.UUID(2), .NAME("z1"), .WIDTH(8), .CHANNELS(2),
      .DEPTH(3), .HOLD_LAST(1)) u_z1 (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .in_en(in_en), .in_data(in_data),
      .out_en(en1), .out_data(d1), .busy(b1));

   zbuffer_pipe #(.UUID(3), .NAME("zs"), .WIDTH(1), .CHANNELS(1),
      .DEPTH(1), .HOLD_LAST(0)) u_zs (
      .clk(clk), .rst(s_rst), .stall(s_stall), .flush(s_flush),
      .in_en(s_en), .in_data(s_din),
      .out_en(s_oen), .out_data(s_dout), .busy(s_busy));

   typedef struct {
      logic        r, s, f;
      logic [1:0]  en;
      logic [15:0] d;
      logic [1:0]  xen;
      logic [15:0] xd, xh;
      logic        xb;
   } vec_t;

   vec_t tv[$];

   task automatic add(input logic r, s, f, input logic [1:0] en,
      input logic [15:0] d, input logic [1:0] xen,
      input logic [15:0] xd, xh, input logic xb);
      vec_t v;
      v.r = r; v.s = s; v.f = f; v.en = en; v.d = d;
      v.xen = xen; v.xd = xd; v.xh = xh; v.xb = xb;
      tv.push_back(v);
   endtask

   task automatic chk(input string nm, input int idx,
      input logic [15:0] act, input logic [15:0] exp);
      if (act !== exp) begin
         nmiss++;
         $display("FAIL %s vec %0d: got %h want %h", nm, idx, act, exp);
      end
   endtask

   task automatic sstep(input logic r, s, f, en, din,
      input logic xen, xd, xb);
      s_rst = r; s_stall = s; s_flush = f; s_en = en; s_din = din;
      @(posedge clk);
      #1;
      nvec++;
      chk("s_out_en", nvec, {15'd0, s_oen}, {15'd0, xen});
      chk("s_out_data", nvec, {15'd0, s_dout}, {15'd0, xd});
      chk("s_busy", nvec, {15'd0, s_busy}, {15'd0, xb});
   endtask

   initial begin
      rst = 1; stall = 0; flush = 0; in_en = 0; in_data = 0;
      s_rst = 1; s_stall = 0; s_flush = 0; s_en = 0; s_din = 0;

      //  r  s  f  en     data      xen    xd        xh        xb
      add(1, 0, 0, 2'b00, 16'h0000, 2'b00, 16'h0000, 16'h0000, 0);
      add(1, 0, 0, 2'b11, 16'hFFFF, 2'b00, 16'h0000, 16'h0000, 0);
      // single channel-0 entry, channel-1 data must be dropped
      add(0, 0, 0, 2'b01, 16'h77A5, 2'b00, 16'h0000, 16'h0000, 1);
      add(0, 0, 0, 2'b00, 16'hFFFF, 2'b00, 16'h0000, 16'h0000, 1);
      add(0, 0, 0, 2'b00, 16'hFFFF, 2'b01, 16'h00A5, 16'h00A5, 1);
      add(0, 0, 0, 2'b00, 16'hFFFF, 2'b00, 16'h0000, 16'h00A5, 0);
      // both channels, hold keeps last word
      add(0, 0, 0, 2'b11, 16'h3C5A, 2'b00, 16'h0000, 16'h00A5, 1);
      add(0, 0, 0, 2'b00, 16'hFFFF, 2'b00, 16'h0000, 16'h00A5, 1);
      add(0, 0, 0, 2'b00, 16'hFFFF, 2'b11, 16'h3C5A, 16'h3C5A, 1);
      add(0, 0, 0, 2'b00, 16'hFFFF, 2'b00, 16'h0000, 16'h3C5A, 0);
      // channel 1 only: hold of channel 0 untouched
      add(0, 0, 0, 2'b10, 16'h9911, 2'b00, 16'h0000, 16'h3C5A, 1);
      add(0, 0, 0, 2'b00, 16'h0000, 2'b00, 16'h0000, 16'h3C5A, 1);
      add(0, 0, 0, 2'b00, 16'h0000, 2'b10, 16'h9900, 16'h995A, 1);
      add(0, 0, 0, 2'b00, 16'h0000, 2'b00, 16'h0000, 16'h995A, 0);
      // stall four edges with entry in stage 1
      add(0, 0, 0, 2'b01, 16'h0042, 2'b00, 16'h0000, 16'h995A, 1);
      add(0, 0, 0, 2'b00, 16'h0000, 2'b00, 16'h0000, 16'h995A, 1);
      add(0, 1, 0, 2'b11, 16'hFFFF, 2'b00, 16'h0000, 16'h995A, 1);
      add(0, 1, 0, 2'b11, 16'hFFFF, 2'b00, 16'h0000, 16'h995A, 1);
      add(0, 1, 0, 2'b11, 16'hFFFF, 2'b00, 16'h0000, 16'h995A, 1);
      add(0, 1, 0, 2'b11, 16'hFFFF, 2'b00, 16'h0000, 16'h995A, 1);
      add(0, 0, 0, 2'b00, 16'h0000, 2'b01, 16'h0042, 16'h9942, 1);
      add(0, 0, 0, 2'b00, 16'h0000, 2'b00, 16'h0000, 16'h9942, 0);
      // fill all stages, then flush+stall together
      add(0, 0, 0, 2'b11, 16'h1111, 2'b00, 16'h0000, 16'h9942, 1);
      add(0, 0, 0, 2'b01, 16'h2222, 2'b00, 16'h0000, 16'h9942, 1);
      add(0, 0, 0, 2'b10, 16'h3333, 2'b11, 16'h1111, 16'h1111, 1);
      add(0, 1, 1, 2'b11, 16'h4444, 2'b00, 16'h0000, 16'h0000, 0);
      add(0, 0, 0, 2'b00, 16'h0000, 2'b00, 16'h0000, 16'h0000, 0);
      add(0, 0, 0, 2'b00, 16'h0000, 2'b00, 16'h0000, 16'h0000, 0);
      add(0, 0, 0, 2'b00, 16'h0000, 2'b00, 16'h0000, 16'h0000, 0);
      // reset mid-stream discards in-flight entries
      add(0, 0, 0, 2'b11, 16'h0101, 2'b00, 16'h0000, 16'h0000, 1);
      add(1, 0, 0, 2'b11, 16'h0202, 2'b00, 16'h0000, 16'h0000, 0);
      add(1, 0, 0, 2'b11, 16'h0303, 2'b00, 16'h0000, 16'h0000, 0);
      add(0, 0, 0, 2'b00, 16'h0000, 2'b00, 16'h0000, 16'h0000, 0);
      add(0, 0, 0, 2'b00, 16'h0000, 2'b00, 16'h0000, 16'h0000, 0);
      add(0, 0, 0, 2'b00, 16'h0000, 2'b00, 16'h0000, 16'h0000, 0);
      // back-to-back streaming, mixed enables
      add(0, 0, 0, 2'b11, 16'h0A0B, 2'b00, 16'h0000, 16'h0000, 1);
      add(0, 0, 0, 2'b01, 16'h0C0D, 2'b00, 16'h0000, 16'h0000, 1);
      add(0, 0, 0, 2'b10, 16'h0E0F, 2'b11, 16'h0A0B, 16'h0A0B, 1);
      add(0, 0, 0, 2'b00, 16'h0000, 2'b01, 16'h000D, 16'h0A0D, 1);
      add(0, 0, 0, 2'b00, 16'h0000, 2'b10, 16'h0E00, 16'h0E0D, 1);
      add(0, 0, 0, 2'b00, 16'h0000, 2'b00, 16'h0000, 16'h0E0D, 0);
      // reset overrides stall
      add(0, 0, 0, 2'b01, 16'h0055, 2'b00, 16'h0000, 16'h0E0D, 1);
      add(1, 1, 0, 2'b00, 16'h0000, 2'b00, 16'h0000, 16'h0000, 0);

      foreach (tv[i]) begin
         rst = tv[i].r; stall = tv[i].s; flush = tv[i].f;
         in_en = tv[i].en; in_data = tv[i].d;
         @(posedge clk);
         #1;
         nvec++;
         chk("out_en", i, {14'd0, en0}, {14'd0, tv[i].xen});
         chk("out_data", i, d0, tv[i].xd);
         chk("busy", i, {15'd0, b0}, {15'd0, tv[i].xb});
         chk("hold_out_en", i, {14'd0, en1}, {14'd0, tv[i].xen});
         chk("hold_out_data", i, d1, tv[i].xh);
         chk("hold_busy", i, {15'd0, b1}, {15'd0, tv[i].xb});
      end

      // DEPTH=1 instance: one-edge latency
      //    r  s  f  en din  xen xd xb
      sstep(1, 0, 0, 1, 1,   0,  0, 0);
      sstep(0, 0, 0, 1, 1,   1,  1, 1);
      sstep(0, 0, 0, 0, 1,   0,  0, 0);
      sstep(0, 0, 0, 1, 0,   1,  0, 1);
      sstep(0, 0, 0, 1, 1,   1,  1, 1);
      sstep(0, 1, 0, 0, 0,   1,  1, 1);
      sstep(0, 1, 1, 1, 1,   0,  0, 0);
      sstep(0, 0, 0, 0, 0,   0,  0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
      $finish;
   end

endmodule
